sent_rx_write_arbiter: RTL

SENT_RX_WRITE_ARBITER -- requirements
Module: sent_rx_write_arbiter

---
 rtl/sent_rx_pkg.sv | 35 +++
 rtl/sent_rx_write_arbiter_if.sv | 12 +
 rtl/sent_rx_fast_buf.sv | 61 ++++++
 rtl/sent_rx_write_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sent_rx_pkg.sv
// Shared types for the SENT receive write arbiter: FSM states, slow-message
// fields, RX FIFO word width/tags and the three-word slow packing.
package sent_rx_pkg;

  localparam int unsigned WORD_W = 12;

  localparam logic TAG_FAST = 1'b0;
  localparam logic TAG_SLOW = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOW0 = 2'd1,
    ST_SLOW1 = 2'd2,
    ST_SLOW2 = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] data;
    logic [1:0]  format;
    logic        cfg;
    logic        pause;
  } slow_msg_t;

  // W0 = {id, format, config, pause}, W1 = data[15:4], W2 = {data[3:0], 8'h00}
  function automatic logic [WORD_W-1:0] slow_word(input slow_msg_t m, input logic [1:0] idx);
    slow_word = '0;
    case (idx)
      2'd0:    slow_word = {m.id, m.format, m.cfg, m.pause};
      2'd1:    slow_word = m.data[15:4];
      default: slow_word = {m.data[3:0], 8'h00};
    endcase
  endfunction

endpackage

// File: rtl/sent_rx_write_arbiter_if.sv
// RX FIFO write port: the arbiter drives the strobe/data/tag, the FIFO returns full.
interface sent_rx_write_arbiter_if;
  import sent_rx_pkg::*;

  logic              write_enable_rx_o;
  logic [WORD_W-1:0] data_rx_o;
  logic              tag_rx_o;
  logic              write_full;

  modport master (output write_enable_rx_o, data_rx_o, tag_rx_o, input write_full);
  modport slave  (input write_enable_rx_o, data_rx_o, tag_rx_o, output write_full);
endinterface

// File: rtl/sent_rx_fast_buf.sv
// Circular FIFO for decoded fast-channel words; pointers wrap on the power-of-2 depth.
module sent_rx_fast_buf #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 12,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk_rx,
  input  logic             reset_rx,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push, do_pop;

  // A push into a full buffer is still accepted when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it was written.
  always_ff @(posedge clk_rx) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign level = count;
  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);

endmodule

// File: rtl/sent_rx_write_arbiter.sv
// Arbitrates decoded fast words and three-word slow messages onto the RX FIFO,
// with starvation protection for slow messages and atomic slow writes.
module sent_rx_write_arbiter
  import sent_rx_pkg::*;
#(
  parameter int unsigned FAST_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                          clk_rx,
  input  logic                          reset_rx,
  input  logic                          start_i,
  input  logic                          fast_valid_i,
  input  logic [WORD_W-1:0]             fast_data_i,
  input  logic                          slow_valid_i,
  input  logic [7:0]                    slow_id_i,
  input  logic [15:0]                   slow_data_i,
  input  logic [1:0]                    slow_format_i,
  input  logic                          slow_config_i,
  input  logic                          slow_pause_i,
  sent_rx_write_arbiter_if.master       wr,
  output logic [$clog2(FAST_DEPTH):0]   fast_level_o,
  output logic [7:0]                    fast_drop_cnt_o,
  output logic                          slow_overrun_o,
  output logic                          busy_o
);

  localparam int unsigned          STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  slow_msg_t           slow_q;
  logic                slow_pend_q;
  logic [STARVE_W-1:0] starve_q;
  logic                we_q, we_d, tag_q, tag_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [7:0]          drop_q;
  logic                overrun_q;

  logic                fast_grant, slow_grant, slow_release;
  logic                buf_push, buf_pop, buf_full, buf_empty;
  logic [WORD_W-1:0]   buf_rdata;
  logic                fast_drop, slow_accept, slow_drop;

  sent_rx_fast_buf #(.DEPTH(FAST_DEPTH), .WIDTH(WORD_W)) u_fast_buf (
    .clk_rx  (clk_rx),
    .reset_rx(reset_rx),
    .flush   (start_i),
    .push    (buf_push),
    .pop     (buf_pop),
    .wdata   (fast_data_i),
    .rdata   (buf_rdata),
    .level   (fast_level_o),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  // An incoming fast word bypasses an empty buffer so it is written one cycle later.
  assign buf_pop     = fast_grant && !buf_empty;
  assign buf_push    = fast_valid_i && !start_i && !(fast_grant && buf_empty);
  assign fast_drop   = buf_push && buf_full && !buf_pop;
  assign slow_accept = slow_valid_i && !start_i && (!slow_pend_q || slow_release);
  assign slow_drop   = slow_valid_i && !start_i && !slow_accept;

  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    we_d         = 1'b0;
    data_d       = data_q;
    tag_d        = tag_q;
    fast_grant   = 1'b0;
    slow_grant   = 1'b0;
    slow_release = 1'b0;
    if (start_i) begin
      state_d = ST_IDLE;
    end else if (!wr.write_full) begin
      case (state_q)
        ST_IDLE: begin
          if (slow_pend_q && (buf_empty || starve_q == STARVE_MAX)) begin
            slow_grant = 1'b1;
            we_d       = 1'b1;
            data_d     = slow_word(slow_q, 2'd0);
            tag_d      = TAG_SLOW;
            state_d    = ST_SLOW1;
          end else if (!buf_empty || fast_valid_i) begin
            fast_grant = 1'b1;
            we_d       = 1'b1;
            data_d     = buf_empty ? fast_data_i : buf_rdata;
            tag_d      = TAG_FAST;
          end
        end
        // SLOW0 is not entered from IDLE (the grant writes W0 directly); it recovers to W0.
        ST_SLOW0: begin
          we_d    = 1'b1;
          data_d  = slow_word(slow_q, 2'd0);
          tag_d   = TAG_SLOW;
          state_d = ST_SLOW1;
        end
        ST_SLOW1: begin
          we_d    = 1'b1;
          data_d  = slow_word(slow_q, 2'd1);
          tag_d   = TAG_SLOW;
          state_d = ST_SLOW2;
        end
        default: begin
          we_d         = 1'b1;
          data_d       = slow_word(slow_q, 2'd2);
          tag_d        = TAG_SLOW;
          state_d      = ST_IDLE;
          slow_release = 1'b1;
        end
      endcase
    end
  end

  // NOTE: registers take <= so every flop samples pre-edge values of its neighbours.
  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      slow_q      <= '0;
      slow_pend_q <= 1'b0;
      starve_q    <= '0;
      we_q        <= 1'b0;
      data_q      <= '0;
      tag_q       <= 1'b0;
      drop_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      we_q   <= we_d;
      data_q <= data_d;
      tag_q  <= tag_d;
      if (fast_drop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
      if (slow_drop) overrun_q <= 1'b1;
      if (start_i) begin
        slow_pend_q <= 1'b0;
        starve_q    <= '0;
      end else begin
        if (slow_accept) begin
          slow_pend_q <= 1'b1;
          slow_q      <= '{id: slow_id_i, data: slow_data_i, format: slow_format_i,
                           cfg: slow_config_i, pause: slow_pause_i};
        end else if (slow_release) begin
          slow_pend_q <= 1'b0;
        end
        if (slow_grant)
          starve_q <= '0;
        else if (fast_grant && slow_pend_q && starve_q != STARVE_MAX)
          starve_q <= starve_q + 1'b1;
      end
    end
  end

  assign wr.write_enable_rx_o = we_q;
  assign wr.data_rx_o         = data_q;
  assign wr.tag_rx_o          = tag_q;
  assign fast_drop_cnt_o      = drop_q;
  assign slow_overrun_o       = overrun_q;
  assign busy_o               = !buf_empty || slow_pend_q || (state_q != ST_IDLE);

endmodule
